// File: rtl/rst_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rst_seq_pkg                                                 |
// | Brief   : Shared FSM state encoding and default parameter values for |
// |           the multi-domain reset sequencer.                          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package rst_seq_pkg;

  // Sequencer FSM states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_RELEASE   = 2'd1,
    ST_RUN       = 2'd2,
    ST_LOCK_LOST = 2'd3
  } rst_seq_state_e;

  localparam int DEF_NUM_DOMAINS = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LOCK_STABLE = 8;
  localparam int DEF_STAGE_DELAY = 16;
  localparam int DEF_SW_MIN      = 4;
  localparam int DEF_TIMEOUT     = 1024;

endpackage
`default_nettype wire

// File: rtl/reset_seq_ctrl_lock_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lock_sync                                                   |
// | Brief   : STAGES-deep flop chain bringing asynchronous PLL lock bits |
// |           into the reference clock domain.                           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module lock_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift the raw lock bits through the chain; reset reads as "not locked".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) chain[s] <= '0;
    end else begin
      chain[0] <= d;
      for (int s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : reset_seq_ctrl                                              |
// | Brief   : Multi-domain reset sequencer. Waits for stable PLL locks,  |
// |           then enables clocks and releases resets domain by domain,  |
// |           re-sequences on lock loss, supports per-domain SW reset.   |
// | Config  : RST_SEQ_LOCK_WDT_EN builds the WAIT_LOCK watchdog.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module reset_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE = DEF_LOCK_STABLE,
  parameter int STAGE_DELAY = DEF_STAGE_DELAY,
  parameter int SW_MIN      = DEF_SW_MIN,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_in_n,
  input  logic [NUM_DOMAINS-1:0] pll_locked,
  input  logic [NUM_DOMAINS-1:0] sw_rst_req,
  output logic [NUM_DOMAINS-1:0] clk_en,
  output logic [NUM_DOMAINS-1:0] rst_out_n,
  output logic                   seq_busy,
  output logic                   all_ready,
  output logic                   lock_timeout
);

  localparam int STW  = $clog2(LOCK_STABLE) + 1;
  localparam int SDW  = $clog2(STAGE_DELAY) + 1;
  localparam int SWW  = $clog2(SW_MIN) + 1;
  localparam int IDXW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  // Counters compare against limit-1 so the increment that would reach the
  // limit coincides with the event edge.
  localparam logic [STW-1:0]  STABLE_M1 = STW'(LOCK_STABLE - 1);
  localparam logic [SDW-1:0]  STAGE_M1  = SDW'(STAGE_DELAY - 1);
  localparam logic [SWW-1:0]  SW_M1     = SWW'(SW_MIN - 1);
  localparam logic [SWW-1:0]  SW_LIM    = SWW'(SW_MIN);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NUM_DOMAINS - 1);

  logic [NUM_DOMAINS-1:0] locked_s;
  logic                   all_locked;

  rst_seq_state_e   state, state_nxt;
  logic [STW-1:0]   stable_cnt, stable_nxt;
  logic [SDW-1:0]   stage_cnt, stage_nxt;
  logic [IDXW-1:0]  idx, idx_nxt;
  logic [SWW-1:0]   sw_cnt     [NUM_DOMAINS];
  logic [SWW-1:0]   sw_cnt_nxt [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] clk_en_nxt, rst_nxt;
  logic             seq_busy_nxt, all_ready_nxt;

  lock_sync #(
    .WIDTH  (NUM_DOMAINS),
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_in_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  assign all_locked = &locked_s;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_nxt  = state;
    stable_nxt = stable_cnt;
    stage_nxt  = stage_cnt;
    idx_nxt    = idx;
    clk_en_nxt = clk_en;
    rst_nxt    = rst_out_n;
    for (int i = 0; i < NUM_DOMAINS; i++) sw_cnt_nxt[i] = sw_cnt[i];

    if ((state == ST_RELEASE || state == ST_RUN) && !all_locked) begin
      // Lock loss overrides any software request on the same edge.
      state_nxt = ST_LOCK_LOST;
      rst_nxt   = '0;
      for (int i = 0; i < NUM_DOMAINS; i++) sw_cnt_nxt[i] = '0;
    end else begin
      case (state)
        ST_WAIT_LOCK: begin
          if (!all_locked) begin
            stable_nxt = '0;
          end else if (stable_cnt >= STABLE_M1) begin
            state_nxt     = ST_RELEASE;
            stable_nxt    = '0;
            stage_nxt     = '0;
            idx_nxt       = '0;
            clk_en_nxt[0] = 1'b1;
          end else begin
            stable_nxt = stable_cnt + STW'(1);
          end
        end
        ST_RELEASE: begin
          if (stage_cnt >= STAGE_M1) begin
            stage_nxt = '0;
            for (int i = 0; i < NUM_DOMAINS; i++)
              if (i == int'(idx)) rst_nxt[i] = 1'b1;
            if (idx == IDX_LAST) begin
              state_nxt = ST_RUN;
            end else begin
              idx_nxt = idx + IDXW'(1);
              for (int i = 0; i < NUM_DOMAINS; i++)
                if (i == int'(idx) + 1) clk_en_nxt[i] = 1'b1;
            end
          end else begin
            stage_nxt = stage_cnt + SDW'(1);
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (sw_rst_req[i]) begin
              // Count low cycles from the edge that pulls reset down.
              rst_nxt[i] = 1'b0;
              if (rst_out_n[i])            sw_cnt_nxt[i] = '0;
              else if (sw_cnt[i] != SW_LIM) sw_cnt_nxt[i] = sw_cnt[i] + SWW'(1);
            end else if (!rst_out_n[i]) begin
              if (sw_cnt[i] >= SW_M1) begin
                rst_nxt[i]    = 1'b1;
                sw_cnt_nxt[i] = '0;
              end else begin
                sw_cnt_nxt[i] = sw_cnt[i] + SWW'(1);
              end
            end
          end
        end
        ST_LOCK_LOST: begin
          // Resets went low one edge earlier; now gate the clocks.
          state_nxt  = ST_WAIT_LOCK;
          clk_en_nxt = '0;
          stable_nxt = '0;
          stage_nxt  = '0;
          idx_nxt    = '0;
        end
        default: state_nxt = ST_WAIT_LOCK;
      endcase
    end

    seq_busy_nxt  = (state_nxt != ST_RUN);
    all_ready_nxt = (state_nxt == ST_RUN) && (&rst_nxt);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state      <= ST_WAIT_LOCK;
      stable_cnt <= '0;
      stage_cnt  <= '0;
      idx        <= '0;
      clk_en     <= '0;
      rst_out_n  <= '0;
      seq_busy   <= 1'b1;
      all_ready  <= 1'b0;
      for (int i = 0; i < NUM_DOMAINS; i++) sw_cnt[i] <= '0;
    end else begin
      state      <= state_nxt;
      stable_cnt <= stable_nxt;
      stage_cnt  <= stage_nxt;
      idx        <= idx_nxt;
      clk_en     <= clk_en_nxt;
      rst_out_n  <= rst_nxt;
      seq_busy   <= seq_busy_nxt;
      all_ready  <= all_ready_nxt;
      for (int i = 0; i < NUM_DOMAINS; i++) sw_cnt[i] <= sw_cnt_nxt[i];
    end
  end

`ifdef RST_SEQ_LOCK_WDT_EN
  localparam int WDW = $clog2(TIMEOUT) + 1;
  localparam logic [WDW-1:0] WDT_M1  = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WDT_LIM = WDW'(TIMEOUT);

  logic [WDW-1:0] wdt_cnt;

  // Watchdog on time spent in WAIT_LOCK; the flag is sticky until rst_in_n.
  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      wdt_cnt      <= '0;
      lock_timeout <= 1'b0;
    end else if (state == ST_WAIT_LOCK) begin
      if (wdt_cnt != WDT_LIM) wdt_cnt <= wdt_cnt + WDW'(1);
      if (wdt_cnt >= WDT_M1)  lock_timeout <= 1'b1;
    end else begin
      wdt_cnt <= '0;
    end
  end
`else
  // TIMEOUT only matters when the watchdog is built.
  localparam int unused_timeout = TIMEOUT;
  assign lock_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reset_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_reset_seq_ctrl                                           |
// | Brief   : Directed table-driven bench for reset_seq_ctrl at default  |
// |           parameters, plus async-reset, WAIT_LOCK glitch and         |
// |           (with RST_SEQ_LOCK_WDT_EN) watchdog sequences.              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_reset_seq_ctrl;

  logic       clk;
  logic       rst_in_n;
  logic [3:0] pll_locked;
  logic [3:0] sw_rst_req;
  logic [3:0] clk_en;
  logic [3:0] rst_out_n;
  logic       seq_busy;
  logic       all_ready;
  logic       lock_timeout;

  int checks = 0;
  int errors = 0;
  int cur_edge = 0;

  typedef struct {
    int         edge_n;
    logic [3:0] pll;
    logic [3:0] sw;
    logic [3:0] exp_clk;
    logic [3:0] exp_rst;
    logic       exp_rdy;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  reset_seq_ctrl dut (
    .clk          (clk),
    .rst_in_n     (rst_in_n),
    .pll_locked   (pll_locked),
    .sw_rst_req   (sw_rst_req),
    .clk_en       (clk_en),
    .rst_out_n    (rst_out_n),
    .seq_busy     (seq_busy),
    .all_ready    (all_ready),
    .lock_timeout (lock_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "time limit");
  end

  // One reference edge, then settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
    cur_edge++;
  endtask

  task automatic step_to(input int e);
    while (cur_edge < e) step();
  endtask

  // Bundle = {clk_en, rst_out_n, all_ready, seq_busy, lock_timeout}.
  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] act;
    act = {clk_en, rst_out_n, all_ready, seq_busy, lock_timeout};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got clk_en=%b rst_out_n=%b rdy=%b busy=%b to=%b, expected clk_en=%b rst_out_n=%b rdy=%b busy=%b to=%b",
               name, cur_edge, act[10:7], act[6:3], act[2], act[1], act[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic void add(input int e, input logic [3:0] p, input logic [3:0] s,
                              input logic [3:0] c, input logic [3:0] r,
                              input logic rdy, input logic busy);
    vec_t v;
    v.edge_n = e; v.pll = p; v.sw = s;
    v.exp_clk = c; v.exp_rst = r; v.exp_rdy = rdy; v.exp_busy = busy;
    vecs.push_back(v);
  endfunction

  initial begin
    // Outputs are checked at the listed edge, then the row's inputs are driven
    // (an input driven at edge e is first captured at edge e+1).
    //   edge  pll     sw      clk_en  rst_n   rdy   busy
    add(  0, 4'hF, 4'h0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    add(  9, 4'hF, 4'h0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    add( 10, 4'hF, 4'h0, 4'b0001, 4'b0000, 1'b0, 1'b1);
    add( 25, 4'hF, 4'h0, 4'b0001, 4'b0000, 1'b0, 1'b1);
    add( 26, 4'hF, 4'h0, 4'b0011, 4'b0001, 1'b0, 1'b1);
    add( 41, 4'hF, 4'h0, 4'b0011, 4'b0001, 1'b0, 1'b1);
    add( 42, 4'hF, 4'h0, 4'b0111, 4'b0011, 1'b0, 1'b1);
    add( 57, 4'hF, 4'h0, 4'b0111, 4'b0011, 1'b0, 1'b1);
    add( 58, 4'hF, 4'h0, 4'b1111, 4'b0111, 1'b0, 1'b1);
    add( 73, 4'hF, 4'h0, 4'b1111, 4'b0111, 1'b0, 1'b1);
    add( 74, 4'hF, 4'h0, 4'b1111, 4'b1111, 1'b1, 1'b0);
    // SW reset of domain 3 for one cycle
    add( 80, 4'hF, 4'h8, 4'b1111, 4'b1111, 1'b1, 1'b0);
    add( 81, 4'hF, 4'h0, 4'b1111, 4'b0111, 1'b0, 1'b0);
    add( 84, 4'hF, 4'h0, 4'b1111, 4'b0111, 1'b0, 1'b0);
    add( 85, 4'hF, 4'h0, 4'b1111, 4'b1111, 1'b1, 1'b0);
    // pll_locked[1] drops in RUN: locked_s low at 92
    add( 90, 4'hD, 4'h0, 4'b1111, 4'b1111, 1'b1, 1'b0);
    add( 92, 4'hD, 4'h0, 4'b1111, 4'b1111, 1'b1, 1'b0);
    add( 93, 4'hD, 4'h0, 4'b1111, 4'b0000, 1'b0, 1'b1);
    add( 94, 4'hD, 4'h0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    // relock; SW request during RELEASE must be ignored
    add(100, 4'hF, 4'h0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    add(109, 4'hF, 4'h0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    add(110, 4'hF, 4'h0, 4'b0001, 4'b0000, 1'b0, 1'b1);
    add(112, 4'hF, 4'h1, 4'b0001, 4'b0000, 1'b0, 1'b1);
    add(120, 4'hF, 4'h0, 4'b0001, 4'b0000, 1'b0, 1'b1);
    add(126, 4'hF, 4'h0, 4'b0011, 4'b0001, 1'b0, 1'b1);
    add(142, 4'hF, 4'h0, 4'b0111, 4'b0011, 1'b0, 1'b1);
    add(158, 4'hF, 4'h0, 4'b1111, 4'b0111, 1'b0, 1'b1);
    add(173, 4'hF, 4'h0, 4'b1111, 4'b0111, 1'b0, 1'b1);
    add(174, 4'hF, 4'h0, 4'b1111, 4'b1111, 1'b1, 1'b0);
    // lock drop and SW request seen on the same edge (183): lock loss wins
    add(180, 4'hB, 4'h0, 4'b1111, 4'b1111, 1'b1, 1'b0);
    add(182, 4'hB, 4'h2, 4'b1111, 4'b1111, 1'b1, 1'b0);
    add(183, 4'hB, 4'h0, 4'b1111, 4'b0000, 1'b0, 1'b1);
    add(184, 4'hB, 4'h0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    add(190, 4'hF, 4'h0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    add(199, 4'hF, 4'h0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    add(200, 4'hF, 4'h0, 4'b0001, 4'b0000, 1'b0, 1'b1);

    rst_in_n   = 1'b0;
    pll_locked = 4'h0;
    sw_rst_req = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0});
    rst_in_n = 1'b1;
    cur_edge = 0;

    foreach (vecs[n]) begin
      step_to(vecs[n].edge_n);
      check($sformatf("vec%0d", n),
            {vecs[n].exp_clk, vecs[n].exp_rst, vecs[n].exp_rdy, vecs[n].exp_busy, 1'b0});
      pll_locked = vecs[n].pll;
      sw_rst_req = vecs[n].sw;
    end

    // Asynchronous reset mid-RELEASE, checked between clock edges.
    step_to(205);
    #2;
    rst_in_n = 1'b0;
    #1;
    check("async_reset", {4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0});

    // Glitch on pll_locked[2] during WAIT_LOCK restarts the stable count.
    repeat (2) @(posedge clk);
    #1;
    rst_in_n   = 1'b1;
    pll_locked = 4'hF;
    cur_edge   = 0;
    step_to(5);
    pll_locked = 4'hB;
    step_to(8);
    pll_locked = 4'hF;
    step_to(10);
    check("glitch_e10", {4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0});
    step_to(13);
    check("glitch_e13", {4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0});
    step_to(17);
    check("glitch_e17", {4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0});
    step_to(18);
    check("glitch_e18", {4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0});

`ifdef RST_SEQ_LOCK_WDT_EN
    // Locks held low: the watchdog fires at edge 1024 and stays set.
    rst_in_n   = 1'b0;
    pll_locked = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_in_n = 1'b1;
    cur_edge = 0;
    step_to(1023);
    check("wdt_e1023", {4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0});
    step_to(1024);
    check("wdt_e1024", {4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1});
    pll_locked = 4'hF;
    step_to(1034);
    check("wdt_e1034", {4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
